// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the internal-bus arbiter: source count, select width,
// FSM encodings and a one-hot helper.
package bus_arbiter_pkg;

  localparam int NUM_SRC = 8;
  localparam int SRC_W   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01,
    StTurn  = 2'b10
  } state_e;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SRC_W-1:0] idx);
    logic [NUM_SRC-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and mux-select signals of the shared 8-bit internal bus.
// master: requester side; slave: arbiter side.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic               lock;
  logic [NUM_SRC-1:0] grant;
  logic               S1;
  logic               S2;
  logic               S3;
  logic               bus_valid;
  logic [SRC_W-1:0]   owner_id;

  modport master (
    output req, lock,
    input  grant, S1, S2, S3, bus_valid, owner_id
  );

  modport slave (
    input  req, lock,
    output grant, S1, S2, S3, bus_valid, owner_id
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: searches rr_ptr+1 .. rr_ptr+8
// (mod 8) and reports the first set request.
module rr_picker
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic               any,
  output logic [SRC_W-1:0]   winner
);

  logic [SRC_W-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = rr_ptr + SRC_W'(i);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared internal bus, with a one-cycle
// turnaround between owners, bounded tenure and an owner lock.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  bus_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SRC_W-1:0]   sel_q, sel_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  logic               any;
  logic [SRC_W-1:0]   winner;
  logic               at_max;
  logic               others;
  logic               release_bus;

  rr_picker u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .any    (any),
    .winner (winner)
  );

  assign at_max      = (hold_q == CNT_W'(MAX_HOLD));
  assign others      = |(bus.req & ~onehot(sel_q));
  // Dropping req always releases; lock only shields against tenure preemption.
  assign release_bus = !bus.req[sel_q] || (at_max && !bus.lock && others);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    unique case (state_q)
      StIdle, StTurn: begin
        if (any) begin
          state_d = StGrant;
          grant_d = onehot(winner);
          sel_d   = winner;
          hold_d  = CNT_W'(1);
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (release_bus) begin
          state_d  = StTurn;
          grant_d  = '0;
          rr_ptr_d = sel_q;
        end else if (!at_max) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      sel_q    <= '0;
      rr_ptr_q <= SRC_W'(NUM_SRC - 1);
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  // Select lines only move on entry to a grant, so an idle bus never toggles the mux.
  assign bus.grant     = grant_q;
  assign bus.S1        = sel_q[2];
  assign bus.S2        = sel_q[1];
  assign bus.S3        = sel_q[0];
  assign bus.owner_id  = sel_q;
  assign bus.bus_valid = |grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues the expected per-cycle bus
// state, a negedge monitor pops and compares it against the DUT.
module tb_bus_arbiter;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bus_arbiter_if bus ();

  bus_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic push(input logic [7:0] g, input logic [2:0] s);
    exp_t e;
    e.grant = g;
    e.sel   = s;
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs just after the edge; expect g/s from the edge just taken.
  task automatic cyc(input logic [7:0] r, input logic l, input logic [7:0] g,
                     input logic [2:0] s);
    @(posedge clk);
    #1;
    bus.req  = r;
    bus.lock = l;
    push(g, s);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_grant"}, bus.grant, 8'h00);
    check({tag, "_valid"}, 8'(bus.bus_valid), 8'h00);
    check({tag, "_sel"}, 8'({bus.S1, bus.S2, bus.S3}), 8'h00);
    check({tag, "_owner"}, 8'(bus.owner_id), 8'h00);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    bus.req  = 8'h00;
    bus.lock = 1'b0;
    #1;
    check_cleared("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("grant", bus.grant, mon_e.grant);
      check("bus_valid", 8'(bus.bus_valid), 8'(|mon_e.grant));
      check("sel", 8'({bus.S1, bus.S2, bus.S3}), 8'(mon_e.sel));
      check("owner_id", 8'(bus.owner_id), 8'(mon_e.sel));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req  = 8'h00;
    bus.lock = 1'b0;
    #7;
    check_cleared("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: single requester 2, drop, select lines hold 010 afterwards.
    cyc(8'h04, 1'b0, 8'h00, 3'd0);
    cyc(8'h00, 1'b0, 8'h04, 3'd2);
    cyc(8'h00, 1'b0, 8'h00, 3'd2);
    cyc(8'h00, 1'b0, 8'h00, 3'd2);
    cyc(8'h00, 1'b0, 8'h00, 3'd2);

    // 2: everyone requesting: 4-cycle tenures, one dead cycle, order 0..7,0.
    apply_reset();
    cyc(8'hFF, 1'b0, 8'h00, 3'd0);
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < 4; h++) cyc(8'hFF, 1'b0, 8'(1 << k), 3'(k));
      cyc(8'hFF, 1'b0, 8'h00, 3'(k));
    end
    cyc(8'hFF, 1'b0, 8'h01, 3'd0);
    cyc(8'h00, 1'b0, 8'h01, 3'd0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0);

    // 3: owner 3 locks against waiting source 0, then unlocks.
    apply_reset();
    cyc(8'h08, 1'b0, 8'h00, 3'd0);
    for (int k = 0; k < 10; k++) cyc(8'h09, 1'b1, 8'h08, 3'd3);
    cyc(8'h09, 1'b0, 8'h08, 3'd3);
    cyc(8'h09, 1'b0, 8'h00, 3'd3);
    cyc(8'h00, 1'b0, 8'h01, 3'd0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0);

    // 4: sole requester 5 keeps the bus; saturated tenure yields at once to a newcomer.
    apply_reset();
    cyc(8'h20, 1'b0, 8'h00, 3'd0);
    for (int k = 0; k < 20; k++) cyc(8'h20, 1'b0, 8'h20, 3'd5);
    cyc(8'h21, 1'b0, 8'h20, 3'd5);
    cyc(8'h21, 1'b0, 8'h00, 3'd5);
    cyc(8'h00, 1'b0, 8'h01, 3'd0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0);

    // 5: owner 6 drops req exactly as tenure saturates, source 1 waiting.
    apply_reset();
    cyc(8'h40, 1'b0, 8'h00, 3'd0);
    cyc(8'h40, 1'b0, 8'h40, 3'd6);
    cyc(8'h40, 1'b0, 8'h40, 3'd6);
    cyc(8'h40, 1'b0, 8'h40, 3'd6);
    cyc(8'h02, 1'b0, 8'h40, 3'd6);
    cyc(8'h02, 1'b0, 8'h00, 3'd6);
    cyc(8'h00, 1'b0, 8'h02, 3'd1);
    cyc(8'h00, 1'b0, 8'h00, 3'd1);

    // 6: asynchronous reset between edges while source 4 owns the bus.
    apply_reset();
    cyc(8'h10, 1'b0, 8'h00, 3'd0);
    cyc(8'h10, 1'b0, 8'h10, 3'd4);
    @(posedge clk);
    #3;
    reset   = 1'b1;
    bus.req = 8'h00;
    #1;
    check_cleared("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.req  = 8'h80;
    bus.lock = 1'b0;
    push(8'h00, 3'd0);
    cyc(8'h00, 1'b0, 8'h80, 3'd7);
    cyc(8'h00, 1'b0, 8'h00, 3'd7);

    repeat (2) @(posedge clk);
    #1;
    check("drain", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
